// File: rtl/rip_decode_queue_pkg.sv
// Shared types for the RV32I decode queue: the inst_t flag set, the decoded bundle and opcode constants.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable. The optional macro RIP_M_EXT_EN only changes decoding; these fields exist in both builds.
package rip_common;

   // The widest PC the bundle can carry. The queue truncates this to its own PC_WIDTH.
   localparam int PC_W_MAX = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_M    = 7'b0000001;

   // One-hot instruction flags followed by the pipeline-control flags.
   typedef struct packed {
      logic LUI, AUIPC, JAL, JALR;
      logic BEQ, BNE, BLT, BGE, BLTU, BGEU;
      logic LB, LH, LW, LBU, LHU;
      logic SB, SH, SW;
      logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
      logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
      logic FENCE, ECALL, EBREAK, MRET;
      logic CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI;
      logic MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
      logic UPDATE_REG, UPDATE_CSR, UPDATE_PC, ACCESS_MEM;
   } inst_t;

   typedef struct packed {
      logic [PC_W_MAX-1:0] pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [11:0]         csr;
      logic [4:0]          zimm;
      logic [31:0]         imm;
      inst_t               inst;
      logic                illegal;
   } dec_bundle_t;

endpackage

// File: rtl/rip_decode_queue_if.sv
// Fetch-side and execute-side signals of the decode queue grouped in one bundle.
// Latency: none (wiring only).
// Backpressure: in_ready from the slave side, out_ready from the master side.
interface rip_decode_queue_if #(parameter int PC_WIDTH = 32, parameter int DEPTH = 2);
   import rip_common::*;

   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              in_inst_code;
   logic [PC_WIDTH-1:0]      in_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [PC_WIDTH-1:0]      out_pc;
   logic [4:0]               out_rs1_num;
   logic [4:0]               out_rs2_num;
   logic [4:0]               out_rd_num;
   logic [11:0]              out_csr_num;
   logic [4:0]               out_csr_zimm;
   logic [31:0]              out_imm;
   inst_t                    out_inst;
   logic                     out_illegal;
   logic [$clog2(DEPTH):0]   count;

   // The decode queue's view.
   modport slave (
      input  flush, in_valid, in_inst_code, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rs1_num, out_rs2_num, out_rd_num,
             out_csr_num, out_csr_zimm, out_imm, out_inst, out_illegal, count
   );

   // The fetch/execute (or bench) view.
   modport master (
      output flush, in_valid, in_inst_code, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1_num, out_rs2_num, out_rd_num,
             out_csr_num, out_csr_zimm, out_imm, out_inst, out_illegal, count
   );
endinterface

// File: rtl/rip_decode_queue_logic.sv
// Combinational RV32I decoder: raw instruction + PC in, decoded bundle out (M extension under RIP_M_EXT_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the bundle is captured.
module rip_decode_logic
   import rip_common::*;
(
   input  logic [31:0]         i_inst_code,
   input  logic [PC_W_MAX-1:0] i_pc,
   output dec_bundle_t         o_bundle
);
   logic [6:0]  w_opc, w_f7;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
   inst_t       w_inst;
   logic [31:0] w_imm;
   logic [11:0] w_csr;
   logic [4:0]  w_zimm;
   logic        w_use_rd, w_use_rs1, w_use_rs2, w_illegal;
   logic [4:0]  w_rd;

   assign w_opc    = i_inst_code[6:0];
   assign w_f3     = i_inst_code[14:12];
   assign w_f7     = i_inst_code[31:25];
   assign w_imm_i  = {{20{i_inst_code[31]}}, i_inst_code[31:20]};
   assign w_imm_s  = {{20{i_inst_code[31]}}, i_inst_code[31:25], i_inst_code[11:7]};
   assign w_imm_b  = {{19{i_inst_code[31]}}, i_inst_code[31], i_inst_code[7],
                      i_inst_code[30:25], i_inst_code[11:8], 1'b0};
   assign w_imm_u  = {i_inst_code[31:12], 12'b0};
   assign w_imm_j  = {{11{i_inst_code[31]}}, i_inst_code[31], i_inst_code[19:12],
                      i_inst_code[20], i_inst_code[30:21], 1'b0};
   assign w_imm_sh = {27'b0, i_inst_code[24:20]};

   // Match the encoding to one flag, then derive legality, gated fields and control flags.
   always_comb begin
      w_inst    = '0;
      w_imm     = '0;
      w_csr     = '0;
      w_zimm    = '0;
      w_use_rd  = 1'b0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      case (w_opc)
         OPC_LUI:   begin w_inst.LUI = 1'b1;   w_imm = w_imm_u; w_use_rd = 1'b1; end
         OPC_AUIPC: begin w_inst.AUIPC = 1'b1; w_imm = w_imm_u; w_use_rd = 1'b1; end
         OPC_JAL:   begin w_inst.JAL = 1'b1;   w_imm = w_imm_j; w_use_rd = 1'b1; end
         OPC_JALR: begin
            w_inst.JALR = (w_f3 == 3'b000);
            w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            case (w_f3)
               3'b000:  w_inst.BEQ  = 1'b1;
               3'b001:  w_inst.BNE  = 1'b1;
               3'b100:  w_inst.BLT  = 1'b1;
               3'b101:  w_inst.BGE  = 1'b1;
               3'b110:  w_inst.BLTU = 1'b1;
               3'b111:  w_inst.BGEU = 1'b1;
               default: ;
            endcase
         end
         OPC_LOAD: begin
            w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            case (w_f3)
               3'b000:  w_inst.LB  = 1'b1;
               3'b001:  w_inst.LH  = 1'b1;
               3'b010:  w_inst.LW  = 1'b1;
               3'b100:  w_inst.LBU = 1'b1;
               3'b101:  w_inst.LHU = 1'b1;
               default: ;
            endcase
         end
         OPC_STORE: begin
            w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            case (w_f3)
               3'b000:  w_inst.SB = 1'b1;
               3'b001:  w_inst.SH = 1'b1;
               3'b010:  w_inst.SW = 1'b1;
               default: ;
            endcase
         end
         OPC_OP_IMM: begin
            w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            case (w_f3)
               3'b000: w_inst.ADDI  = 1'b1;
               3'b010: w_inst.SLTI  = 1'b1;
               3'b011: w_inst.SLTIU = 1'b1;
               3'b100: w_inst.XORI  = 1'b1;
               3'b110: w_inst.ORI   = 1'b1;
               3'b111: w_inst.ANDI  = 1'b1;
               3'b001: begin
                  w_imm = w_imm_sh;
                  w_inst.SLLI = (w_f7 == FUNCT7_ZERO);
               end
               default: begin
                  w_imm = w_imm_sh;
                  w_inst.SRLI = (w_f7 == FUNCT7_ZERO);
                  w_inst.SRAI = (w_f7 == FUNCT7_ALT);
               end
            endcase
         end
         OPC_OP: begin
            w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            if (w_f7 == FUNCT7_ZERO) begin
               case (w_f3)
                  3'b000:  w_inst.ADD  = 1'b1;
                  3'b001:  w_inst.SLL  = 1'b1;
                  3'b010:  w_inst.SLT  = 1'b1;
                  3'b011:  w_inst.SLTU = 1'b1;
                  3'b100:  w_inst.XOR  = 1'b1;
                  3'b101:  w_inst.SRL  = 1'b1;
                  3'b110:  w_inst.OR   = 1'b1;
                  default: w_inst.AND  = 1'b1;
               endcase
            end else if (w_f7 == FUNCT7_ALT) begin
               w_inst.SUB = (w_f3 == 3'b000);
               w_inst.SRA = (w_f3 == 3'b101);
            end
`ifdef RIP_M_EXT_EN
            else if (w_f7 == FUNCT7_M) begin
               case (w_f3)
                  3'b000:  w_inst.MUL    = 1'b1;
                  3'b001:  w_inst.MULH   = 1'b1;
                  3'b010:  w_inst.MULHSU = 1'b1;
                  3'b011:  w_inst.MULHU  = 1'b1;
                  3'b100:  w_inst.DIV    = 1'b1;
                  3'b101:  w_inst.DIVU   = 1'b1;
                  3'b110:  w_inst.REM    = 1'b1;
                  default: w_inst.REMU   = 1'b1;
               endcase
            end
`endif
         end
         OPC_MISC_MEM: w_inst.FENCE = (w_f3 == 3'b000);
         OPC_SYSTEM: begin
            if (w_f3 == 3'b000) begin
               w_inst.ECALL  = (i_inst_code == 32'h0000_0073);
               w_inst.EBREAK = (i_inst_code == 32'h0010_0073);
               w_inst.MRET   = (i_inst_code == 32'h3020_0073);
            end else if (w_f3 != 3'b100) begin
               w_csr     = i_inst_code[31:20];
               w_use_rd  = 1'b1;
               w_use_rs1 = !w_f3[2];
               w_zimm    = w_f3[2] ? i_inst_code[19:15] : 5'd0;
               case (w_f3)
                  3'b001:  w_inst.CSRRW  = 1'b1;
                  3'b010:  w_inst.CSRRS  = 1'b1;
                  3'b011:  w_inst.CSRRC  = 1'b1;
                  3'b101:  w_inst.CSRRWI = 1'b1;
                  3'b110:  w_inst.CSRRSI = 1'b1;
                  default: w_inst.CSRRCI = 1'b1;
               endcase
            end
         end
         default: ;
      endcase

      // An encoding is legal exactly when it raised one instruction flag.
      w_illegal = (w_inst == '0);
      if (w_illegal) begin
         w_imm     = '0;
         w_csr     = '0;
         w_zimm    = '0;
         w_use_rd  = 1'b0;
         w_use_rs1 = 1'b0;
         w_use_rs2 = 1'b0;
      end
      w_rd = w_use_rd ? i_inst_code[11:7] : 5'd0;

      w_inst.UPDATE_REG = (w_rd != 5'd0) && !w_illegal;
      w_inst.UPDATE_CSR = (w_opc == OPC_SYSTEM) && (w_f3 != 3'b000) && !w_illegal;
      w_inst.UPDATE_PC  = w_inst.JAL | w_inst.JALR | w_inst.BEQ | w_inst.BNE | w_inst.BLT |
                          w_inst.BGE | w_inst.BLTU | w_inst.BGEU | w_inst.ECALL |
                          w_inst.EBREAK | w_inst.MRET;
      w_inst.ACCESS_MEM = w_inst.LB | w_inst.LH | w_inst.LW | w_inst.LBU | w_inst.LHU |
                          w_inst.SB | w_inst.SH | w_inst.SW;
   end

   assign o_bundle.pc      = i_pc;
   assign o_bundle.rs1     = w_use_rs1 ? i_inst_code[19:15] : 5'd0;
   assign o_bundle.rs2     = w_use_rs2 ? i_inst_code[24:20] : 5'd0;
   assign o_bundle.rd      = w_rd;
   assign o_bundle.csr     = w_csr;
   assign o_bundle.zimm    = w_zimm;
   assign o_bundle.imm     = w_imm;
   assign o_bundle.inst    = w_inst;
   assign o_bundle.illegal = w_illegal;
endmodule

// File: rtl/rip_decode_queue.sv
// Decode stage with a DEPTH-entry FIFO of decoded bundles between fetch and execute (M ext via RIP_M_EXT_EN).
// Latency: a push into an empty queue is visible at the head one edge later; no combinational pass-through.
// Backpressure: in_ready = !full from registered count; flush drops the queue and any same-cycle push/pop.
module rip_decode_queue
   import rip_common::*;
#(
   parameter int DEPTH    = 2,
   parameter int PC_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   rip_decode_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);

   dec_bundle_t  w_dec;
   dec_bundle_t  w_head;
   dec_bundle_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          w_full, w_empty, w_push, w_pop;

   rip_decode_logic u_dec (
      .i_inst_code (q.in_inst_code),
      .i_pc        (PC_W_MAX'(q.in_pc)),
      .o_bundle    (w_dec)
   );

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = q.in_valid && !w_full && !q.flush;
   assign w_pop   = !w_empty && q.out_ready && !q.flush;

   // Capture the freshly decoded bundle; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_dec;
   end

   // Pointers and occupancy; flush empties the queue ahead of any push or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (q.flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head = w_empty ? '0 : r_mem[r_rptr];

   assign q.in_ready     = !w_full;
   assign q.out_valid    = !w_empty;
   assign q.count        = r_count;
   assign q.out_pc       = PC_WIDTH'(w_head.pc);
   assign q.out_rs1_num  = w_head.rs1;
   assign q.out_rs2_num  = w_head.rs2;
   assign q.out_rd_num   = w_head.rd;
   assign q.out_csr_num  = w_head.csr;
   assign q.out_csr_zimm = w_head.zimm;
   assign q.out_imm      = w_head.imm;
   assign q.out_inst     = w_head.inst;
   assign q.out_illegal  = w_head.illegal;
endmodule

// File: tb/tb_rip_decode_queue.sv
// Scoreboard bench for rip_decode_queue: directed instructions, full/flush/reset corner cases.
// Expected bundles are queued at push time and compared by a monitor when the head is consumed.
// Build with or without RIP_M_EXT_EN; the MUL expectation follows the macro.
module tb_rip_decode_queue;
   import rip_common::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nchk = 0;
   int   nerr = 0;
   dec_bundle_t sb [$];
   inst_t ei;

   rip_decode_queue_if #(.PC_WIDTH(32), .DEPTH(2)) q ();
   rip_decode_queue #(.DEPTH(2), .PC_WIDTH(32)) dut (.clk(clk), .rst(rst), .q(q));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic dec_bundle_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic [11:0] csr, input logic [4:0] zimm,
                                      input logic [31:0] imm, input inst_t inst, input logic ill);
      dec_bundle_t b;
      b.pc = pc; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.csr = csr;
      b.zimm = zimm; b.imm = imm; b.inst = inst; b.illegal = ill;
      return b;
   endfunction

   // Monitor: every consumed head is compared with the oldest expected bundle.
   always @(negedge clk) begin
      dec_bundle_t a, e;
      if (!rst && q.out_valid && q.out_ready && !q.flush) begin
         a = mk(q.out_pc, q.out_rs1_num, q.out_rs2_num, q.out_rd_num, q.out_csr_num,
                q.out_csr_zimm, q.out_imm, q.out_inst, q.out_illegal);
         nchk++;
         if (sb.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_pop: actual pc %0h required no output", q.out_pc);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               nerr++;
               $display("FAIL bundle pc=%0h: actual %0h required %0h", e.pc, a, e);
            end
         end
      end
   end

   // Present one instruction until accepted, recording its expected bundle.
   task automatic push(input logic [31:0] code, input logic [31:0] pc, input dec_bundle_t e);
      int t = 0;
      q.in_valid = 1'b1; q.in_inst_code = code; q.in_pc = pc;
      while (!q.in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!q.in_ready) begin
         chk("push_timeout", 64'(q.in_ready), 64'd1);
      end else begin
         sb.push_back(e);
         @(posedge clk); #1;
      end
      q.in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int t = 0;
      q.out_ready = 1'b1;
      while ((q.count != 0 || sb.size() != 0) && t < 40) begin
         @(posedge clk); #1; t++;
      end
      chk("drain", 64'(q.count), 64'd0);
   endtask

   initial begin
      q.flush = 1'b0; q.in_valid = 1'b0; q.in_inst_code = '0; q.in_pc = '0; q.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(q.out_valid), 64'd0);
      chk("rst_count", 64'(q.count), 64'd0);
      chk("rst_ready", 64'(q.in_ready), 64'd1);
      chk("rst_inst", 64'(q.out_inst), 64'd0);
      chk("rst_imm", 64'(q.out_imm), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // ADDI x1,x2,-1 into an empty queue with execute stalled.
      q.in_valid = 1'b1; q.in_inst_code = 32'hFFF10093; q.in_pc = 32'h100;
      #1;
      chk("no_passthru_valid", 64'(q.out_valid), 64'd0);
      chk("no_passthru_rd", 64'(q.out_rd_num), 64'd0);
      ei = '0; ei.ADDI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'hFFF10093, 32'h100, mk(32'h100, 5'd2, 5'd0, 5'd1, 12'h0, 5'd0, 32'hFFFFFFFF, ei, 1'b0));
      chk("addi_valid", 64'(q.out_valid), 64'd1);
      chk("addi_count", 64'(q.count), 64'd1);
      chk("addi_rd", 64'(q.out_rd_num), 64'd1);
      q.out_ready = 1'b1;

      // Streaming with execute always ready: push and pop overlap.
      ei = '0; ei.SRAI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'h40335293, 32'h104, mk(32'h104, 5'd6, 5'd0, 5'd5, 12'h0, 5'd0, 32'h3, ei, 1'b0));
      ei = '0; ei.CSRRWI = 1'b1; ei.UPDATE_CSR = 1'b1;
      push(32'h3002D073, 32'h108, mk(32'h108, 5'd0, 5'd0, 5'd0, 12'h300, 5'd5, 32'h0, ei, 1'b0));
      chk("stream_count", 64'(q.count), 64'd1);
`ifdef RIP_M_EXT_EN
      ei = '0; ei.MUL = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'h022081B3, 32'h10C, mk(32'h10C, 5'd1, 5'd2, 5'd3, 12'h0, 5'd0, 32'h0, ei, 1'b0));
`else
      push(32'h022081B3, 32'h10C, mk(32'h10C, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
`endif
      push(32'h0000007F, 32'h110, mk(32'h110, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      ei = '0; ei.LW = 1'b1; ei.UPDATE_REG = 1'b1; ei.ACCESS_MEM = 1'b1;
      push(32'h0081A383, 32'h114, mk(32'h114, 5'd3, 5'd0, 5'd7, 12'h0, 5'd0, 32'h8, ei, 1'b0));
      ei = '0; ei.SW = 1'b1; ei.ACCESS_MEM = 1'b1;
      push(32'hFE512E23, 32'h118, mk(32'h118, 5'd2, 5'd5, 5'd0, 12'h0, 5'd0, 32'hFFFFFFFC, ei, 1'b0));
      ei = '0; ei.BEQ = 1'b1; ei.UPDATE_PC = 1'b1;
      push(32'h00208463, 32'h11C, mk(32'h11C, 5'd1, 5'd2, 5'd0, 12'h0, 5'd0, 32'h8, ei, 1'b0));
      push(32'h0020A463, 32'h120, mk(32'h120, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      ei = '0; ei.LUI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'h12345537, 32'h124, mk(32'h124, 5'd0, 5'd0, 5'd10, 12'h0, 5'd0, 32'h12345000, ei, 1'b0));
      ei = '0; ei.JAL = 1'b1; ei.UPDATE_REG = 1'b1; ei.UPDATE_PC = 1'b1;
      push(32'h010000EF, 32'h128, mk(32'h128, 5'd0, 5'd0, 5'd1, 12'h0, 5'd0, 32'h10, ei, 1'b0));
      push(32'h042081B3, 32'h12C, mk(32'h12C, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      ei = '0; ei.ECALL = 1'b1; ei.UPDATE_PC = 1'b1;
      push(32'h00000073, 32'h130, mk(32'h130, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, ei, 1'b0));
      wait_empty();

      // Fill to DEPTH, hold a third instruction, then pop once.
      q.out_ready = 1'b0;
      ei = '0; ei.ADDI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'hFFF10093, 32'h200, mk(32'h200, 5'd2, 5'd0, 5'd1, 12'h0, 5'd0, 32'hFFFFFFFF, ei, 1'b0));
      ei = '0; ei.SRAI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'h40335293, 32'h204, mk(32'h204, 5'd6, 5'd0, 5'd5, 12'h0, 5'd0, 32'h3, ei, 1'b0));
      q.in_valid = 1'b1; q.in_inst_code = 32'h12345537; q.in_pc = 32'h208;
      @(posedge clk); #1;
      chk("full_count", 64'(q.count), 64'd2);
      chk("full_ready", 64'(q.in_ready), 64'd0);
      q.out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_ready_same_cycle", 64'(q.in_ready), 64'd0);
      @(posedge clk); #1;
      q.out_ready = 1'b0;
      chk("after_pop_count", 64'(q.count), 64'd1);
      chk("after_pop_ready", 64'(q.in_ready), 64'd1);
      ei = '0; ei.LUI = 1'b1; ei.UPDATE_REG = 1'b1;
      sb.push_back(mk(32'h208, 5'd0, 5'd0, 5'd10, 12'h0, 5'd0, 32'h12345000, ei, 1'b0));
      @(posedge clk); #1;
      q.in_valid = 1'b0;
      chk("third_accepted_count", 64'(q.count), 64'd2);
      wait_empty();

      // Flush while full with a concurrent push and pop.
      q.out_ready = 1'b0;
      push(32'h0000007F, 32'h300, mk(32'h300, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      push(32'h0000007F, 32'h304, mk(32'h304, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      q.in_valid = 1'b1; q.in_inst_code = 32'hFFF10093; q.in_pc = 32'h308;
      q.out_ready = 1'b1; q.flush = 1'b1;
      @(posedge clk); #1;
      q.flush = 1'b0; q.in_valid = 1'b0; q.out_ready = 1'b0;
      sb.delete();
      chk("flush_full_count", 64'(q.count), 64'd0);
      chk("flush_full_valid", 64'(q.out_valid), 64'd0);

      // Flush with one entry and a concurrent push.
      push(32'h0000007F, 32'h310, mk(32'h310, 5'd0, 5'd0, 5'd0, 12'h0, 5'd0, 32'h0, '0, 1'b1));
      q.in_valid = 1'b1; q.in_inst_code = 32'hFFF10093; q.in_pc = 32'h314; q.flush = 1'b1;
      @(posedge clk); #1;
      q.flush = 1'b0; q.in_valid = 1'b0;
      sb.delete();
      chk("flush_partial_count", 64'(q.count), 64'd0);

      // Asynchronous reset while full.
      ei = '0; ei.LUI = 1'b1; ei.UPDATE_REG = 1'b1;
      push(32'h12345537, 32'h400, mk(32'h400, 5'd0, 5'd0, 5'd10, 12'h0, 5'd0, 32'h12345000, ei, 1'b0));
      push(32'h12345537, 32'h404, mk(32'h404, 5'd0, 5'd0, 5'd10, 12'h0, 5'd0, 32'h12345000, ei, 1'b0));
      chk("pre_rst_count", 64'(q.count), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(q.out_valid), 64'd0);
      chk("arst_count", 64'(q.count), 64'd0);
      chk("arst_pc", 64'(q.out_pc), 64'd0);
      chk("arst_imm", 64'(q.out_imm), 64'd0);
      chk("arst_rd", 64'(q.out_rd_num), 64'd0);
      chk("arst_inst", 64'(q.out_inst), 64'd0);
      sb.delete();
      @(negedge clk); rst = 1'b0;
      ei = '0; ei.JAL = 1'b1; ei.UPDATE_REG = 1'b1; ei.UPDATE_PC = 1'b1;
      push(32'h010000EF, 32'h500, mk(32'h500, 5'd0, 5'd0, 5'd1, 12'h0, 5'd0, 32'h10, ei, 1'b0));
      chk("post_rst_valid", 64'(q.out_valid), 64'd1);
      chk("post_rst_count", 64'(q.count), 64'd1);
      wait_empty();

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
